free_tag_list: RTL and testbench
================================

// Module: free_tag_list
// PURPOSE
//  Circular free list of physical-register tags for the rename stage.
//  Rename pops (allocates) one free tag per cycle. Commit pushes (releases) one retired tag per cycle.
//  Tag storage is a bank of enable-gated per-bit flops, indexed by head and tail pointers.
//  Sits between commit (release side) and rename (allocate side).
// PARAMETERS
//  TAG_W     6   width of a tag; NUM_TAGS = 2**TAG_W (64)
//  RESERVED  32  tags 0..RESERVED-1 are architecturally mapped at reset, so they are not free
// PORTS
//  clk          in   1        rising-edge clock
//  reset        in   1        synchronous, active-low: state resets on any clk edge where reset==0
//  alloc_req    in   1        rename requests one tag this cycle
//  alloc_tag    out  TAG_W    tag at head; meaningful only when alloc_valid==1
//  alloc_valid  out  1        list non-empty (== ~empty)
//  release_en   in   1        commit returns release_tag this cycle
//  release_tag  in   TAG_W    tag being freed
//  count        out  TAG_W+1  number of free tags held (0..NUM_TAGS)
//  empty        out  1        count==0
//  full         out  1        count==NUM_TAGS
//  err          out  1        sticky protocol-violation flag
// BEHAVIOUR
//  Storage: NUM_TAGS entries x TAG_W bits, plus head, tail (TAG_W bits, wrap mod NUM_TAGS) and count.
//  Reset state (clk edge with reset==0):
//   - entry[i] = RESERVED+i for i < NUM_TAGS-RESERVED; other entries = 0
//   - head = 0; tail = NUM_TAGS-RESERVED (mod NUM_TAGS)
//   - count = NUM_TAGS-RESERVED; err = 0
//   - So after reset: alloc_tag = RESERVED, alloc_valid = 1, empty = 0, full = 0 (defaults).
//  Outputs are combinational from registered state:
//   - alloc_tag = entry[head]
//   - empty, full and alloc_valid derive from count
//   - Zero-latency read: the tag is presented in the same cycle it is popped.
//  pop = alloc_req & ~empty
//   - On pop: head <= head+1 (wraps 63 -> 0).
//  push = release_en & ~full
//   - On push: entry[tail] <= release_tag; tail <= tail+1 (wraps).
//  count <= count + push - pop. Pop and push may occur in the same cycle:
//   - count unchanged
//   - The pop takes the old head entry.
//   - The push writes the tail entry. It never writes the head entry, because count>0.
//  Empty with alloc_req=1 and release_en=1: no bypass.
//   - alloc_valid stays 0 and no pop occurs.
//   - The push happens; the released tag becomes alloc_tag in the next cycle.
//  Full with release_en=1 (and no pop): the release is dropped and no state changes except err<=1.
//   - If a pop occurs in the same cycle, the release is still dropped. push is evaluated against the pre-edge full.
//  alloc_req while empty: no pop, err<=1.
//  err stays set until reset; it does not block normal operation.
//  No tag-uniqueness checking. Releasing a tag twice is the caller's fault and is not detected.
//  reset==0 mid-operation overrides all inputs that cycle and restores the reset state exactly.
// TESTING
//  1. Release reset, idle -> count=32, alloc_tag=32, alloc_valid=1, empty=0, full=0, err=0.
//  2. alloc_req=1 for 32 cycles -> alloc_tag 32,33,...,63 in order; then count=0, empty=1,
//     alloc_valid=0. A 33rd alloc_req -> err=1, count stays 0.
//  3. From empty, release 5 then 9 (no alloc) -> count=2, alloc_tag=5. Alloc -> alloc_tag=9, count=1.
//  4. After reset, alloc_req=1 and release_en=1 with tag 7 in the same cycle -> popped tag 32, count stays 32.
//     Drain 31 more -> tags 33..63, then 7.
//  5. Reach full (count=64) via releases. Release tag 3 -> dropped, err=1, count=64.
//     Alloc+release in the same cycle at full -> release dropped, count=63.
//     Drive 40+ mixed ops across the pointer wrap -> FIFO order preserved.
//  6. Mid-sequence (count=10, head=22), drive reset=0 for one edge with alloc_req=1 -> next cycle
//     count=32, alloc_tag=32, err=0; reset=1 with alloc_req=0 -> state holds.

Source files
------------

// File: rtl/free_tag_list.sv
`default_nettype none
// ============================================================================
// Module      : free_tag_list
// Description : Circular free list of physical-register tags for the rename
//               stage. Rename pops (allocates) one free tag per cycle from the
//               head; commit pushes (releases) one retired tag per cycle at the
//               tail. Tag storage is a bank of enable-gated per-entry flops.
//
// Ports
//   clk          in   1        rising-edge clock
//   reset        in   1        synchronous, active-low reset
//   alloc_req    in   1        rename requests one tag this cycle
//   alloc_tag    out  TAG_W    tag at head (meaningful when alloc_valid=1)
//   alloc_valid  out  1        list non-empty
//   release_en   in   1        commit returns release_tag this cycle
//   release_tag  in   TAG_W    tag being freed
//   count        out  TAG_W+1  number of free tags held (0..2**TAG_W)
//   empty        out  1        count == 0
//   full         out  1        count == 2**TAG_W
//   err          out  1        sticky protocol-violation flag
//
// Revision    : 1.0  initial release
// ============================================================================
module free_tag_list #(
    parameter int TAG_W    = 6,
    parameter int RESERVED = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc_req,
    output logic [TAG_W-1:0] alloc_tag,
    output logic             alloc_valid,
    input  logic             release_en,
    input  logic [TAG_W-1:0] release_tag,
    output logic [TAG_W:0]   count,
    output logic             empty,
    output logic             full,
    output logic             err
);

    localparam int c_num_tags  = 1 << TAG_W;
    // Tags RESERVED..NUM_TAGS-1 are the ones free out of reset.
    localparam int c_init_free = c_num_tags - RESERVED;

    logic [TAG_W-1:0]  r_entry [c_num_tags];
    logic [TAG_W-1:0]  r_head;
    logic [TAG_W-1:0]  r_tail;
    logic [TAG_W:0]    r_count;
    logic              r_err;

    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic [c_num_tags-1:0] w_wr_en;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (TAG_W+1)'(c_num_tags));

    // Both qualifiers use the pre-edge occupancy, so a release at full is
    // dropped even when a pop frees a slot in the same cycle.
    assign w_pop  = alloc_req  & ~w_empty;
    assign w_push = release_en & ~w_full;

    // ------------------------------------------------------------------
    // Tag storage: one enable-gated register per entry, written only at
    // the tail. With count > 0 during a simultaneous pop, tail != head, so
    // a push never overwrites the entry being read.
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < c_num_tags; i++) begin : g_entry
            localparam logic [TAG_W-1:0] c_rst_val =
                (i < c_init_free) ? TAG_W'(RESERVED + i) : '0;

            assign w_wr_en[i] = w_push && (r_tail == TAG_W'(i));

            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_entry[i] <= c_rst_val;
                end else if (w_wr_en[i]) begin
                    r_entry[i] <= release_tag;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pointers, occupancy and sticky error. Pointers wrap naturally at
    // 2**TAG_W through their width.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= TAG_W'(c_init_free);
            r_count <= (TAG_W+1)'(c_init_free);
            r_err   <= 1'b0;
        end else begin
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            // Allocating from empty or releasing into full is a caller
            // protocol error; it is recorded but never blocks operation.
            if ((alloc_req && w_empty) || (release_en && w_full)) begin
                r_err <= 1'b1;
            end
        end
    end

    // Zero-latency read: the head tag is visible in the cycle it is popped.
    assign alloc_tag   = r_entry[r_head];
    assign alloc_valid = ~w_empty;
    assign count       = r_count;
    assign empty       = w_empty;
    assign full        = w_full;
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_free_tag_list.sv
`default_nettype none
// ============================================================================
// Module      : tb_free_tag_list
// Description : Self-checking bench for free_tag_list. A queue-based model of
//               the free list is compared against the DUT every cycle, with
//               directed sequences pinned by literal expectations and a
//               randomized mixed-operation phase.
// Revision    : 1.0  initial release
// ============================================================================
module tb_free_tag_list;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       alloc_req = 1'b0;
    logic       release_en = 1'b0;
    logic [5:0] release_tag = '0;
    logic [5:0] alloc_tag;
    logic       alloc_valid;
    logic [6:0] count;
    logic       empty;
    logic       full;
    logic       err;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Reference model: FIFO of free tags plus sticky error.
    int q[$];
    bit m_err = 1'b0;

    always #5 clk = ~clk;

    free_tag_list #(.TAG_W(6), .RESERVED(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .alloc_req   (alloc_req),
        .alloc_tag   (alloc_tag),
        .alloc_valid (alloc_valid),
        .release_en  (release_en),
        .release_tag (release_tag),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .err         (err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model update on every rising edge from the inputs applied that cycle.
    initial begin
        forever begin
            bit do_pop;
            bit do_push;
            @(posedge clk);
            if (!reset) begin
                q.delete();
                for (int i = 0; i < 32; i++) q.push_back(32 + i);
                m_err = 1'b0;
            end else begin
                do_pop  = alloc_req  && (q.size() != 0);
                do_push = release_en && (q.size() != 64);
                if (alloc_req && q.size() == 0)   m_err = 1'b1;
                if (release_en && q.size() == 64) m_err = 1'b1;
                if (do_pop)  void'(q.pop_front());
                if (do_push) q.push_back(int'(release_tag));
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("count",       32'(count),       32'(q.size()));
            chk("empty",       32'(empty),       32'(q.size() == 0));
            chk("full",        32'(full),        32'(q.size() == 64));
            chk("alloc_valid", 32'(alloc_valid), 32'(q.size() != 0));
            chk("err",         32'(err),         32'(m_err));
            if (q.size() != 0) chk("alloc_tag", 32'(alloc_tag), 32'(q[0]));
        end
    end

    // Apply inputs for one cycle (called at a falling edge).
    task automatic step(input bit a, input bit r, input logic [5:0] t);
        alloc_req   = a;
        release_en  = r;
        release_tag = t;
        @(negedge clk);
    endtask

    initial begin
        // 1. Reset state
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset  = 1'b1;
        chk_en = 1'b1;
        step(0, 0, 0);
        chk("t1_count", 32'(count), 32);
        chk("t1_tag",   32'(alloc_tag), 32);
        chk("t1_valid", 32'(alloc_valid), 1);
        chk("t1_empty", 32'(empty), 0);
        chk("t1_full",  32'(full), 0);
        chk("t1_err",   32'(err), 0);

        // 2. Drain all 32 free tags in order, then over-allocate
        for (int i = 0; i < 32; i++) begin
            chk("t2_tag", 32'(alloc_tag), 32'(32 + i));
            step(1, 0, 0);
        end
        chk("t2_count", 32'(count), 0);
        chk("t2_empty", 32'(empty), 1);
        chk("t2_valid", 32'(alloc_valid), 0);
        chk("t2_err0",  32'(err), 0);
        step(1, 0, 0);
        chk("t2_err1",  32'(err), 1);
        chk("t2_count_hold", 32'(count), 0);

        // 3. Empty with alloc+release: no bypass; then FIFO order of releases
        step(1, 1, 6'd5);
        chk("t3_count_a", 32'(count), 1);
        chk("t3_tag_a",   32'(alloc_tag), 5);
        step(0, 1, 6'd9);
        chk("t3_count_b", 32'(count), 2);
        chk("t3_tag_b",   32'(alloc_tag), 5);
        step(1, 0, 0);
        chk("t3_tag_c",   32'(alloc_tag), 9);
        chk("t3_count_c", 32'(count), 1);
        step(1, 0, 0);

        // 4. Simultaneous alloc+release after reset
        reset = 1'b0;
        step(1, 1, 6'd7);
        reset = 1'b1;
        chk("t4_count_rst", 32'(count), 32);
        chk("t4_err_rst",   32'(err), 0);
        step(1, 1, 6'd7);
        chk("t4_count", 32'(count), 32);
        chk("t4_tag0",  32'(alloc_tag), 33);
        for (int i = 0; i < 31; i++) begin
            chk("t4_tag", 32'(alloc_tag), 32'(33 + i));
            step(1, 0, 0);
        end
        chk("t4_tag7",   32'(alloc_tag), 7);
        chk("t4_count1", 32'(count), 1);

        // 5. Fill, overfill, alloc+release at full, random mixed traffic
        reset = 1'b0;
        step(0, 0, 0);
        reset = 1'b1;
        for (int i = 0; i < 32; i++) step(0, 1, 6'($urandom));
        chk("t5_count_full", 32'(count), 64);
        chk("t5_full",       32'(full), 1);
        chk("t5_err0",       32'(err), 0);
        step(0, 1, 6'd3);
        chk("t5_count_drop", 32'(count), 64);
        chk("t5_err1",       32'(err), 1);
        step(1, 1, 6'd3);
        chk("t5_count_63",   32'(count), 63);
        chk("t5_full0",      32'(full), 0);
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom));
        end

        // 6. Reset mid-sequence with alloc_req asserted
        for (int i = 0; i < 200 && q.size() != 10; i++) begin
            if (q.size() > 10) step(1, 0, 0);
            else               step(0, 1, 6'($urandom));
        end
        chk("t6_count10", 32'(count), 10);
        step(0, 1, 6'd1);
        step(1, 0, 0);
        chk("t6_err_set", 32'(err), 1);
        reset = 1'b0;
        step(1, 0, 0);
        reset = 1'b1;
        chk("t6_count_rst", 32'(count), 32);
        chk("t6_tag_rst",   32'(alloc_tag), 32);
        chk("t6_err_rst",   32'(err), 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0);
            chk("t6_hold_count", 32'(count), 32);
            chk("t6_hold_tag",   32'(alloc_tag), 32);
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
